// File: rtl/rom_load_sequencer_pkg.sv
// Shared definitions for the Pooyan ROM download sequencer: region map,
// FSM state and region encodings, and the region-to-strobe helper.
package pooyan_load_pkg;

   localparam logic [15:0] CPU_BASE  = 16'h0000;
   localparam logic [15:0] CPU_SIZE  = 16'h8000;
   localparam logic [15:0] SND_BASE  = 16'h8000;
   localparam logic [15:0] SND_SIZE  = 16'h2000;
   localparam logic [15:0] CHR_BASE  = 16'hA000;
   localparam logic [15:0] CHR_SIZE  = 16'h2000;
   localparam logic [15:0] SPR_BASE  = 16'hC000;
   localparam logic [15:0] SPR_SIZE  = 16'h2000;
   localparam logic [15:0] PROM_BASE = 16'hE000;
   localparam logic [15:0] PROM_SIZE = 16'h0220;
   localparam logic [15:0] MAP_END   = 16'hE220;

   typedef enum logic [1:0] {IDLE, LOAD, SETTLE, RUN} load_state_t;

   typedef enum logic [2:0] {RG_CPU, RG_SND, RG_CHR, RG_SPR, RG_PROM, RG_NONE} region_t;

   // One-hot strobe vector, bit 0 = CPU ... bit 4 = PROM.
   function automatic logic [4:0] region_strobe(input region_t rg);
      logic [4:0] s;
      s = '0;
      case (rg)
         RG_CPU:  s = 5'b00001;
         RG_SND:  s = 5'b00010;
         RG_CHR:  s = 5'b00100;
         RG_SPR:  s = 5'b01000;
         RG_PROM: s = 5'b10000;
         default: s = 5'b00000;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/rom_load_sequencer_if.sv
// Bundle between hps_io download side and the Pooyan core ROM write side.
//   master: drives dn_* (download source), observes the sequencer outputs.
//   slave : the sequencer; takes dn_*, drives strobes, address/data, status.
interface rom_load_sequencer_if;
   logic        dn_download;
   logic        dn_wr;
   logic [24:0] dn_addr;
   logic [7:0]  dn_data;
   logic        cpu_rom_we;
   logic        snd_rom_we;
   logic        chr_rom_we;
   logic        spr_rom_we;
   logic        prom_we;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   logic        core_reset;
   logic        load_done;
   logic        load_error;
   logic [16:0] byte_count;

   modport master (
      output dn_download, dn_wr, dn_addr, dn_data,
      input  cpu_rom_we, snd_rom_we, chr_rom_we, spr_rom_we, prom_we,
      input  wr_addr, wr_data, core_reset, load_done, load_error, byte_count
   );

   modport slave (
      input  dn_download, dn_wr, dn_addr, dn_data,
      output cpu_rom_we, snd_rom_we, chr_rom_we, spr_rom_we, prom_we,
      output wr_addr, wr_data, core_reset, load_done, load_error, byte_count
   );
endinterface

// File: rtl/rom_load_sequencer_region_decode.sv
// Combinational download-address decoder.
//   dn_addr_i  : 25-bit download byte address
//   region_o   : target region, RG_NONE when outside the map
//   rel_addr_o : address relative to the region base (0 when out of map)
module rom_region_decode
   import pooyan_load_pkg::*;
(
   input  logic [24:0] dn_addr_i,
   output region_t     region_o,
   output logic [15:0] rel_addr_o
);

   logic [15:0] a16;
   assign a16 = dn_addr_i[15:0];

   // Regions are contiguous, so a cascade of upper-bound compares suffices.
   always_comb begin
      region_o   = RG_NONE;
      rel_addr_o = '0;
      if (dn_addr_i[24:16] == 9'd0) begin
         if (a16 < CPU_BASE + CPU_SIZE) begin
            region_o   = RG_CPU;
            rel_addr_o = a16 - CPU_BASE;
         end else if (a16 < SND_BASE + SND_SIZE) begin
            region_o   = RG_SND;
            rel_addr_o = a16 - SND_BASE;
         end else if (a16 < CHR_BASE + CHR_SIZE) begin
            region_o   = RG_CHR;
            rel_addr_o = a16 - CHR_BASE;
         end else if (a16 < SPR_BASE + SPR_SIZE) begin
            region_o   = RG_SPR;
            rel_addr_o = a16 - SPR_BASE;
         end else if (a16 < MAP_END) begin
            region_o   = RG_PROM;
            rel_addr_o = a16 - PROM_BASE;
         end
      end
   end

endmodule

// File: rtl/rom_load_sequencer.sv
// Pooyan ROM download sequencer. Turns the hps_io byte stream into one
// region write strobe per byte, holds the core in reset during and after
// the load, and reports byte count and load errors.
//   clk_sys : system clock
//   reset   : asynchronous active-high reset
//   bus     : slave side of rom_load_sequencer_if (dn_* in, strobes/status out)
//
// state  | meaning
// IDLE   | after reset, waiting for the first download
// LOAD   | download active, accepting bytes
// SETTLE | download finished, core held in reset for SETTLE_CYCLES
// RUN    | core released, load_done high
module rom_load_sequencer
   import pooyan_load_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 64,
   parameter int EXPECTED_BYTES = 57888
) (
   input logic                 clk_sys,
   input logic                 reset,
   rom_load_sequencer_if.slave bus
);

   localparam logic [15:0] SETTLE_INIT = SETTLE_CYCLES[15:0];
   localparam logic [16:0] EXP_COUNT   = EXPECTED_BYTES[16:0];
   localparam logic [16:0] COUNT_MAX   = 17'h1FFFF;

   load_state_t state_q, state_d;
   logic [15:0] settle_q, settle_d;
   logic [16:0] count_q, count_d;
   logic        err_q, err_d;
   logic        dn_wr_q;
   logic [4:0]  we_q, we_d;
   logic [15:0] wr_addr_q, wr_addr_d;
   logic [7:0]  wr_data_q, wr_data_d;
   region_t     region;
   logic [15:0] rel_addr;
   logic        accept;

   rom_region_decode u_decode (
      .dn_addr_i  (bus.dn_addr),
      .region_o   (region),
      .rel_addr_o (rel_addr)
   );

   // Rising edge of dn_wr only, so a held strobe produces a single write.
   assign accept = bus.dn_wr && !dn_wr_q && bus.dn_download && (state_q == LOAD);

   always_comb begin
      state_d   = state_q;
      settle_d  = settle_q;
      count_d   = count_q;
      err_d     = err_q;
      we_d      = '0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;

      if (accept) begin
         if (count_q != COUNT_MAX) count_d = count_q + 17'd1;
         if (region == RG_NONE) begin
            err_d = 1'b1;
         end else begin
            we_d      = region_strobe(region);
            wr_addr_d = rel_addr;
            wr_data_d = bus.dn_data;
         end
      end

      unique case (state_q)
         IDLE, RUN: begin
            if (bus.dn_download) begin
               state_d = LOAD;
               count_d = '0;
               err_d   = 1'b0;
            end
         end
         LOAD: begin
            // accept is gated by dn_download, so count_q is final here.
            if (!bus.dn_download) begin
               state_d  = SETTLE;
               settle_d = SETTLE_INIT;
               if (count_q != EXP_COUNT) err_d = 1'b1;
            end
         end
         SETTLE: begin
            if (bus.dn_download) begin
               state_d = LOAD;
               count_d = '0;
               err_d   = 1'b0;
            end else begin
               settle_d = settle_q - 16'd1;
               if (settle_q == 16'd1) state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         settle_q  <= '0;
         count_q   <= '0;
         err_q     <= 1'b0;
         dn_wr_q   <= 1'b0;
         we_q      <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         settle_q  <= settle_d;
         count_q   <= count_d;
         err_q     <= err_d;
         dn_wr_q   <= bus.dn_wr;
         we_q      <= we_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign bus.cpu_rom_we = we_q[0];
   assign bus.snd_rom_we = we_q[1];
   assign bus.chr_rom_we = we_q[2];
   assign bus.spr_rom_we = we_q[3];
   assign bus.prom_we    = we_q[4];
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.core_reset = (state_q != RUN);
   assign bus.load_done  = (state_q == RUN);
   assign bus.load_error = err_q;
   assign bus.byte_count = count_q;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Randomized self-checking bench for rom_load_sequencer. A smaller expected
// byte count keeps full loads short; the region map is exercised by random
// addresses plus every region boundary.
module tb_rom_load_sequencer;

   localparam int SETTLE = 64;
   localparam int EXP_N  = 1000;

   logic clk_sys = 1'b0;
   logic reset;
   always #5 clk_sys = ~clk_sys;

   rom_load_sequencer_if bus();

   rom_load_sequencer #(
      .SETTLE_CYCLES  (SETTLE),
      .EXPECTED_BYTES (EXP_N)
   ) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   int unsigned rg_base[5] = '{32'h0000, 32'h8000, 32'hA000, 32'hC000, 32'hE000};
   int unsigned rg_size[5] = '{32'h8000, 32'h2000, 32'h2000, 32'h2000, 32'h0220};
   int unsigned bounds[10] = '{32'h0000, 32'h7FFF, 32'h8000, 32'h9FFF, 32'hA000,
                               32'hBFFF, 32'hC000, 32'hDFFF, 32'hE000, 32'hE21F};
   int   exp_count;
   logic exp_err;
   int   exp_cnt[5];
   int   seen[5];

   logic [4:0] we_vec;
   assign we_vec = {bus.prom_we, bus.spr_rom_we, bus.chr_rom_we, bus.snd_rom_we, bus.cpu_rom_we};

   always @(negedge clk_sys) begin
      for (int i = 0; i < 5; i++) if (we_vec[i] === 1'b1) seen[i]++;
   end

   function automatic int ref_region(input int unsigned a);
      for (int i = 0; i < 5; i++)
         if (a >= rg_base[i] && a < rg_base[i] + rg_size[i]) return i;
      return 5;
   endfunction

   function automatic int unsigned rand_in_map();
      return $urandom_range(32'hE21F, 0);
   endfunction

   // Raise dn_download and wait until the sequencer is in LOAD.
   task automatic start_load();
      bus.dn_download = 1'b1;
      bus.dn_wr       = 1'b0;
      @(negedge clk_sys);
      exp_count = 0;
      exp_err   = 1'b0;
      for (int i = 0; i < 5; i++) begin
         exp_cnt[i] = 0;
         seen[i]    = 0;
      end
   endtask

   task automatic write_byte(input int unsigned a, input logic [7:0] d, input int hold);
      int r;
      logic [4:0] exp_we;
      r = ref_region(a);
      bus.dn_addr = a[24:0];
      bus.dn_data = d;
      bus.dn_wr   = 1'b1;
      @(negedge clk_sys);
      if (exp_count < 32'h1FFFF) exp_count++;
      if (r == 5) begin
         exp_err = 1'b1;
         exp_we  = 5'b00000;
      end else begin
         exp_cnt[r]++;
         exp_we = 5'b00001 << r;
      end
      n_checks++;
      if (we_vec !== exp_we) $display("FAIL strobe addr=%h: got %b want %b", a, we_vec, exp_we);
      else n_pass++;
      if (r != 5) begin
         n_checks++;
         if (bus.wr_addr !== 16'(a - rg_base[r]))
            $display("FAIL wr_addr addr=%h: got %h want %h", a, bus.wr_addr, 16'(a - rg_base[r]));
         else n_pass++;
         n_checks++;
         if (bus.wr_data !== d) $display("FAIL wr_data addr=%h: got %h want %h", a, bus.wr_data, d);
         else n_pass++;
      end
      n_checks++;
      if (bus.byte_count !== 17'(exp_count))
         $display("FAIL byte_count: got %0d want %0d", bus.byte_count, exp_count);
      else n_pass++;
      for (int h = 1; h < hold; h++) begin
         @(negedge clk_sys);
         n_checks++;
         if (we_vec !== 5'b00000) $display("FAIL held strobe addr=%h: got %b want 00000", a, we_vec);
         else n_pass++;
      end
      bus.dn_wr = 1'b0;
      @(negedge clk_sys);
   endtask

   // Drop dn_download and measure how many cycles core_reset stays high.
   task automatic end_load(input logic wr_on_fall, output int n_settle);
      bus.dn_download = 1'b0;
      bus.dn_wr       = wr_on_fall;
      if (exp_count != EXP_N) exp_err = 1'b1;
      n_settle = 0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk_sys);
         bus.dn_wr = 1'b0;
         if (bus.core_reset === 1'b1) n_settle++;
         else break;
      end
   endtask

   task automatic check_run(input string tag, input int n_settle);
      n_checks++;
      if (n_settle != SETTLE) $display("FAIL %s settle: got %0d want %0d", tag, n_settle, SETTLE);
      else n_pass++;
      n_checks++;
      if (bus.load_done !== 1'b1) $display("FAIL %s load_done: got %b want 1", tag, bus.load_done);
      else n_pass++;
      n_checks++;
      if (bus.load_error !== exp_err) $display("FAIL %s load_error: got %b want %b", tag, bus.load_error, exp_err);
      else n_pass++;
      n_checks++;
      if (bus.byte_count !== 17'(exp_count))
         $display("FAIL %s final count: got %0d want %0d", tag, bus.byte_count, exp_count);
      else n_pass++;
   endtask

   task automatic check_reset_values(input string tag);
      n_checks++;
      if ({we_vec, bus.wr_addr, bus.wr_data} !== 29'd0)
         $display("FAIL %s we/addr/data: got %b/%h/%h want 0", tag, we_vec, bus.wr_addr, bus.wr_data);
      else n_pass++;
      n_checks++;
      if ({bus.core_reset, bus.load_done, bus.load_error} !== 3'b100)
         $display("FAIL %s status: got %b want 100", tag, {bus.core_reset, bus.load_done, bus.load_error});
      else n_pass++;
      n_checks++;
      if (bus.byte_count !== 17'd0) $display("FAIL %s byte_count: got %0d want 0", tag, bus.byte_count);
      else n_pass++;
   endtask

   task automatic full_clean_load(input string tag);
      int n;
      start_load();
      for (int i = 0; i < 10; i++) write_byte(bounds[i], 8'($urandom), 1);
      for (int i = 10; i < EXP_N; i++) write_byte(rand_in_map(), 8'($urandom), $urandom_range(3, 1));
      end_load(1'b0, n);
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (seen[i] != exp_cnt[i]) $display("FAIL %s region %0d pulses: got %0d want %0d", tag, i, seen[i], exp_cnt[i]);
         else n_pass++;
      end
      check_run(tag, n);
   endtask

   task automatic test_reset();
      reset           = 1'b1;
      bus.dn_download = 1'b0;
      bus.dn_wr       = 1'b0;
      bus.dn_addr     = '0;
      bus.dn_data     = '0;
      #1;
      check_reset_values("reset");
      repeat (3) @(negedge clk_sys);
      reset = 1'b0;
      repeat (4) @(negedge clk_sys);
      check_reset_values("idle");
   endtask

   task automatic test_single_and_held();
      int n;
      start_load();
      write_byte(32'hA005, 8'h5A, 1);
      write_byte(32'h0010, 8'hC3, 5);
      end_load(1'b1, n);
      check_run("single_held", n);
   endtask

   task automatic test_full_load();
      start_load();
      n_checks++;
      if ({bus.core_reset, bus.load_done, bus.byte_count} !== {2'b10, 17'd0})
         $display("FAIL reload entry: got %b/%b/%0d want 1/0/0", bus.core_reset, bus.load_done, bus.byte_count);
      else n_pass++;
      full_clean_load("full");
   endtask

   task automatic test_out_of_map();
      int n;
      int pos_a, pos_b;
      pos_a = $urandom_range(EXP_N - 1, 0);
      pos_b = (pos_a + 7) % EXP_N;
      start_load();
      for (int i = 0; i < EXP_N; i++) begin
         if (i == pos_a)      write_byte(32'hE300, 8'($urandom), 1);
         else if (i == pos_b) write_byte(32'h1_0040, 8'($urandom), 2);
         else                 write_byte(rand_in_map(), 8'($urandom), $urandom_range(2, 1));
      end
      end_load(1'b0, n);
      check_run("out_of_map", n);
   endtask

   task automatic test_short_and_zero();
      int n;
      start_load();
      for (int i = 0; i < 100; i++) write_byte(rand_in_map(), 8'($urandom), 1);
      end_load(1'b0, n);
      check_run("short", n);
      bus.dn_download = 1'b1;
      @(negedge clk_sys);
      n_checks++;
      if ({bus.core_reset, bus.load_done, bus.byte_count} !== {2'b10, 17'd0})
         $display("FAIL rerun entry: got %b/%b/%0d want 1/0/0", bus.core_reset, bus.load_done, bus.byte_count);
      else n_pass++;
      exp_count = 0;
      exp_err   = 1'b0;
      end_load(1'b0, n);
      check_run("zero_byte", n);
   endtask

   task automatic test_reset_mid_load();
      int n;
      start_load();
      bus.dn_addr = 25'h0_0020;
      bus.dn_data = 8'h77;
      bus.dn_wr   = 1'b1;
      @(posedge clk_sys);
      #1;
      n_checks++;
      if (we_vec !== 5'b00001) $display("FAIL pending strobe: got %b want 00001", we_vec);
      else n_pass++;
      reset     = 1'b1;
      bus.dn_wr = 1'b0;
      #1;
      check_reset_values("reset_mid_load");
      @(negedge clk_sys);
      reset = 1'b0;
      @(negedge clk_sys);
      exp_count = 0;
      exp_err   = 1'b0;
      write_byte(32'hC123, 8'h99, 1);
      end_load(1'b0, n);
      check_run("after_mid_load_reset", n);
   endtask

   task automatic test_reset_settle();
      start_load();
      for (int i = 0; i < EXP_N; i++) write_byte(rand_in_map(), 8'($urandom), 1);
      bus.dn_download = 1'b0;
      repeat (35) @(negedge clk_sys);
      n_checks++;
      if (bus.core_reset !== 1'b1) $display("FAIL settle mid: got %b want 1", bus.core_reset);
      else n_pass++;
      reset = 1'b1;
      #1;
      check_reset_values("reset_settle");
      @(negedge clk_sys);
      reset = 1'b0;
      repeat (3) @(negedge clk_sys);
      check_reset_values("post_reset_idle");
      full_clean_load("replay");
   endtask

   initial begin
      test_reset();
      test_single_and_held();
      test_full_load();
      test_out_of_map();
      test_short_and_zero();
      test_reset_mid_load();
      test_reset_settle();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
